// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle command sequencer for an 8x8-bit register file.
// Accepts one command at a time, drives the file's read selects and write port,
// computes ALU results, and sequences the two-write SWAP and eight-write CLR.
module regfile_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_dst,
    input  logic [2:0] cmd_srca,
    input  logic [2:0] cmd_srcb,
    input  logic [7:0] cmd_imm,
    output logic [2:0] asel,
    output logic [2:0] bsel,
    input  logic [7:0] aout,
    input  logic [7:0] bout,
    output logic [2:0] csel,
    output logic       cload,
    output logic [7:0] cin,
    output logic       busy,
    output logic       done,
    output logic [7:0] result
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXEC    = 2'd1;
    localparam logic [1:0] ST_SWAP2   = 2'd2;
    localparam logic [1:0] ST_CLRLOOP = 2'd3;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SWAP = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    logic [1:0] state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] dst_q, dst_d;
    logic [2:0] srca_q, srca_d;
    logic [2:0] srcb_q, srcb_d;
    logic [7:0] imm_q, imm_d;
    logic [7:0] tmp_q, tmp_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic       cload_raw;
    logic       done_raw;

    // Next-state, register-file port drive and ALU; writes and done are masked during reset
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        srca_d    = srca_q;
        srcb_d    = srcb_q;
        imm_d     = imm_q;
        tmp_d     = tmp_q;
        cnt_d     = cnt_q;
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        asel      = 3'd0;
        bsel      = 3'd0;
        csel      = 3'd0;
        cin       = 8'd0;
        cload_raw = 1'b0;
        done_raw  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    srca_d  = cmd_srca;
                    srcb_d  = cmd_srcb;
                    imm_d   = cmd_imm;
                    cnt_d   = 3'd0;
                    state_d = (cmd_op == OP_CLR) ? ST_CLRLOOP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                asel     = srca_q;
                bsel     = srcb_q;
                csel     = dst_q;
                done_raw = 1'b1;
                state_d  = ST_IDLE;
                case (op_q)
                    OP_LDI: begin
                        cin       = imm_q;
                        cload_raw = 1'b1;
                    end
                    OP_MOV: begin
                        cin       = aout;
                        cload_raw = 1'b1;
                    end
                    OP_ADD: begin
                        cin       = aout + bout;
                        cload_raw = 1'b1;
                    end
                    OP_SUB: begin
                        cin       = aout - bout;
                        cload_raw = 1'b1;
                    end
                    OP_XOR: begin
                        cin       = aout ^ bout;
                        cload_raw = 1'b1;
                    end
                    OP_SWAP: begin
                        csel      = srca_q;
                        cin       = bout;
                        cload_raw = 1'b1;
                        tmp_d     = aout;
                        done_raw  = 1'b0;
                        state_d   = ST_SWAP2;
                    end
                    default: begin
                        cload_raw = 1'b0;
                    end
                endcase
            end
            ST_SWAP2: begin
                asel      = srca_q;
                bsel      = srcb_q;
                csel      = srcb_q;
                cin       = tmp_q;
                cload_raw = 1'b1;
                done_raw  = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                csel      = cnt_q;
                cin       = 8'd0;
                cload_raw = 1'b1;
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    done_raw = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
        endcase

        cload    = cload_raw & ~rst;
        done     = done_raw & ~rst;
        result_d = (done && cload) ? cin : result_q;
    end

    // State and latched-command registers; reset discards any in-flight command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'd0;
            dst_q    <= 3'd0;
            srca_q   <= 3'd0;
            srcb_q   <= 3'd0;
            imm_q    <= 8'd0;
            tmp_q    <= 8'd0;
            cnt_q    <= 3'd0;
            result_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            imm_q    <= imm_d;
            tmp_q    <= tmp_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Multi-cycle command sequencer for the 8×8-bit register file. It accepts one command at a time over a valid/ready handshake and drives the file's read selects (`asel`, `bsel`) and write port (`csel`, `cload`, `cin`). It computes results in a small 8-bit ALU, sequences two-write (SWAP) and eight-write (CLR) operations, and reports completion with a `done` pulse plus the last written value.

## Interface
- No parameters; data width is fixed at 8 bits and register count at 8.
- `clk` in 1: single clock; every state change occurs on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is present on `cmd_*`.
- `cmd_ready` out 1: the sequencer can accept a command.
- `cmd_op` in 3: 000 NOP, 001 LDI, 010 MOV, 011 ADD, 100 SUB, 101 SWAP, 110 CLR, 111 XOR.
- `cmd_dst` in 3: destination register.
- `cmd_srca` in 3: source A register.
- `cmd_srcb` in 3: source B register.
- `cmd_imm` in 8: immediate value for LDI.
- `asel` out 3: register file read select A.
- `bsel` out 3: register file read select B.
- `aout` in 8: register file read data A, combinational from `asel`.
- `bout` in 8: register file read data B, combinational from `bsel`.
- `csel` out 3: register file write select.
- `cload` out 1: register file write enable.
- `cin` out 8: register file write data.
- `busy` out 1: a command is executing.
- `done` out 1: one-cycle pulse during the final execution cycle.
- `result` out 8: registered copy of the last value written.

## Operation
- States: IDLE, EXEC, SWAP2, CLRLOOP.
- On acceptance, the command fields are latched into internal registers. `cmd_*` may change freely after acceptance.
- IDLE:
  - `cmd_ready`=1, `busy`=0, `cload`=0, all selects and `cin` = 0.
  - When `cmd_valid`=1: accept. CLR goes to CLRLOOP with counter = 0; every other op goes to EXEC.
- EXEC, all ops: `asel`=srca, `bsel`=srcb.
  - NOP: `cload`=0, `done`=1, go to IDLE. `result` is unchanged.
  - LDI: `csel`=dst, `cin`=imm, `cload`=1.
  - MOV: `cin`=`aout`.
  - ADD: `cin`=(`aout`+`bout`) mod 256; carry is discarded.
  - SUB: `cin`=(`aout`−`bout`) mod 256.
  - XOR: `cin`=`aout`^`bout`.
  - LDI, MOV, ADD, SUB and XOR all write with `csel`=dst, `cload`=1, `done`=1, then go to IDLE.
  - SWAP: `csel`=srca, `cin`=`bout`, `cload`=1. Latch `aout` into tmp, then go to SWAP2 with `done`=0.
- SWAP2: `csel`=srcb, `cin`=tmp, `cload`=1, `done`=1, go to IDLE.
  - srca==srcb is legal: two writes occur and the value is unchanged.
- CLRLOOP: `csel`=counter, `cin`=0, `cload`=1, counter increments each cycle.
  - When counter==7: `done`=1, go to IDLE; the counter wraps to 0.
- `result` is loaded with `cin` on every edge where `done`=1 and `cload`=1.
- `busy` = (state ≠ IDLE); `cmd_ready` = (state == IDLE). Commands cannot be accepted back-to-back while busy.
- `cload` is forced to 0 whenever `rst`=1, so no register file write occurs in a reset cycle.

## Timing
- Reset values after any edge with `rst`=1:
  - state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `cload`=0.
  - `asel`/`bsel`/`csel`=0, `cin`=0, `result`=0, counter=0, tmp=0.
- Reset mid-operation aborts immediately: remaining SWAP2/CLR writes are not issued, and the latched command is discarded.
- Command accepted at edge T:
  - EXEC occupies cycle T→T+1.
  - Write and `result` update occur at edge T+1; the new value is readable from the file in the cycle after T+1.
  - `cmd_ready` returns at T+1.
- Occupancy:
  - NOP, LDI, MOV, ADD, SUB, XOR: 1 busy cycle.
  - SWAP: 2 busy cycles.
  - CLR: 8 busy cycles, with writes in `csel` order 0..7.
- Accept-to-next-accept minimum is 2 cycles for single-cycle ops (IDLE+EXEC), 3 for SWAP and 9 for CLR.
- `done` is high for exactly one cycle per command, including NOP.
- The ALU path is combinational from `aout`/`bout` to `cin` within a single cycle; there is no pipelining.

## Test plan
- Reset, then LDI dst=3 imm=0x5A -> `cload`=1 with `csel`=3 and `cin`=0x5A for one cycle; `done`=1 in that cycle; `result`=0x5A; reading R3 gives 0x5A.
- LDI R1=0xF0, LDI R2=0x20, ADD dst=4 a=1 b=2 -> R4=0x10 (wrap); SUB dst=5 a=2 b=1 -> R5=0x30; XOR dst=6 a=1 b=2 -> R6=0xD0.
- R1=0x11, R2=0x22, SWAP a=1 b=2 -> two consecutive writes (`csel` 1 then 2); R1=0x22, R2=0x11; `done` only on the second write; `result`=0x11. Repeat with a=b=2 -> R2 unchanged.
- Load all registers with nonzero values, then CLR -> 8 consecutive writes with `csel`=0..7 and `cin`=0; `busy` high for 8 cycles; all registers read 0.
- Hold `cmd_valid`=1 with changing `cmd_*` during a CLR -> no acceptance until `cmd_ready`=1; the in-flight command is unaffected.
- Assert `rst` during CLR cycle 4 -> no write in the reset cycle; state IDLE, `done`=0, `result`=0 afterward; the next command executes normally.
